// File: rtl/count_event_monitor.sv
// -----------------------------------------------------------------------------
// count_event_monitor
//
// Watches a free-running 4-bit up-counter. It reports 15->0 wraps and arrivals
// at a programmable match value, keeps an epoch count of wraps, and runs a
// small arm/fire/acknowledge interrupt FSM driven by the match events.
//
// Parameters
//   EPOCH_W    width of the wrap-epoch counter (2..16)
//
// Ports
//   clk        in   single clock, all state updates on the rising edge
//   reset      in   synchronous active-high reset
//   count      in   [3:0] up-counter value, sampled every edge
//   arm        in   enables the interrupt FSM (match detection to FIRED)
//   match_val  in   [3:0] count value that triggers a match
//   irq_ack    in   acknowledges a pending interrupt (only honoured in FIRED)
//   wrap       out  one-cycle pulse per detected 15->0 transition
//   match      out  one-cycle pulse per arrival of count at match_val
//   epoch      out  [EPOCH_W-1:0] wraps seen modulo 2^EPOCH_W
//   irq        out  high exactly while the FSM is in FIRED
//   state      out  [1:0] FSM state: IDLE=0, ARMED=1, FIRED=2
//   seq_err    out  sticky count-sequence error flag
//
// Build option
//   COUNT_SEQ_CHECK_EN  when defined, seq_err flags any sampled count that is
//                       neither a repeat nor a +1 (mod 16) step; when undefined
//                       seq_err is tied low and no checker logic exists.
// -----------------------------------------------------------------------------
module count_event_monitor #(
    parameter int EPOCH_W = 8
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [3:0]         count,
    input  logic               arm,
    input  logic [3:0]         match_val,
    input  logic               irq_ack,
    output logic               wrap,
    output logic               match,
    output logic [EPOCH_W-1:0] epoch,
    output logic               irq,
    output logic [1:0]         state,
    output logic               seq_err
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ARMED = 2'd1,
        ST_FIRED = 2'd2
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [3:0]         r_cnt_q;
    logic               r_cnt_v;
    logic               r_wrap;
    logic               r_match;
    logic [EPOCH_W-1:0] r_epoch;
    logic               w_wrap_hit;
    logic               w_match_hit;

    // Both events need a previous sample, so nothing fires on the first
    // edge after reset. A match is an arrival: a steady count never re-pulses.
    assign w_wrap_hit  = r_cnt_v && (r_cnt_q == 4'd15) && (count == 4'd0);
    assign w_match_hit = r_cnt_v && (count == match_val) && (count != r_cnt_q);

    // Previous-sample register; gated by r_cnt_v, so it needs no reset.
    always_ff @(posedge clk) begin
        r_cnt_q <= count;
    end

    // Stage 1: registered event pulses, epoch count and FSM state
    always_ff @(posedge clk) begin
        if (reset) begin
            r_cnt_v <= 1'b0;
            r_wrap  <= 1'b0;
            r_match <= 1'b0;
            r_epoch <= '0;
            r_state <= ST_IDLE;
        end else begin
            r_cnt_v <= 1'b1;
            r_wrap  <= w_wrap_hit;
            r_match <= w_match_hit;
            if (w_wrap_hit) begin
                r_epoch <= r_epoch + {{(EPOCH_W-1){1'b0}}, 1'b1};
            end
            r_state <= w_state_nxt;
        end
    end

    // Dropping arm beats a coincident match; FIRED ignores arm and matches
    // until acknowledged, so an ack coinciding with a match does not re-fire.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                if (arm) w_state_nxt = ST_ARMED;
            end
            ST_ARMED: begin
                if (!arm)             w_state_nxt = ST_IDLE;
                else if (w_match_hit) w_state_nxt = ST_FIRED;
            end
            ST_FIRED: begin
                if (irq_ack) w_state_nxt = arm ? ST_ARMED : ST_IDLE;
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    assign wrap  = r_wrap;
    assign match = r_match;
    assign epoch = r_epoch;
    assign state = r_state;
    assign irq   = (r_state == ST_FIRED);

`ifdef COUNT_SEQ_CHECK_EN
    logic [3:0] w_cnt_inc;
    logic       w_seq_bad;
    logic       r_seq_err;

    // The 4-bit add wraps 15 to 0, so 15->0 counts as a legal step.
    assign w_cnt_inc = r_cnt_q + 4'd1;
    assign w_seq_bad = r_cnt_v && (count != r_cnt_q) && (count != w_cnt_inc);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_seq_err <= 1'b0;
        end else if (w_seq_bad) begin
            r_seq_err <= 1'b1;
        end
    end

    assign seq_err = r_seq_err;
`else
    assign seq_err = 1'b0;
`endif

endmodule
